// File: rtl/catch_arbiter_if.sv
// Bus between the object modules, the claw controllers and the catch arbiter.
// master drives per-object hit/alive/value and claw status; slave is the arbiter.
interface catch_arbiter_if #(
    parameter int unsigned N_OBJ   = 8,
    parameter int unsigned VAL_W   = 8,
    parameter int unsigned SCORE_W = 14
);
    logic [N_OBJ-1:0]       hit_l;
    logic [N_OBJ-1:0]       hit_r;
    logic [N_OBJ-1:0]       obj_alive;
    logic [N_OBJ*VAL_W-1:0] obj_value;
    logic                   claw_home_l;
    logic                   claw_home_r;
    logic                   is_explodel;
    logic                   is_exploder;

    logic [N_OBJ-1:0]       grant_l;
    logic [N_OBJ-1:0]       grant_r;
    logic                   busy_l;
    logic                   busy_r;
    logic [N_OBJ-1:0]       kill;
    logic [SCORE_W-1:0]     score_l;
    logic [SCORE_W-1:0]     score_r;
    logic                   score_pulse_l;
    logic                   score_pulse_r;

    modport master (
        output hit_l, hit_r, obj_alive, obj_value,
        output claw_home_l, claw_home_r, is_explodel, is_exploder,
        input  grant_l, grant_r, busy_l, busy_r, kill,
        input  score_l, score_r, score_pulse_l, score_pulse_r
    );

    modport slave (
        input  hit_l, hit_r, obj_alive, obj_value,
        input  claw_home_l, claw_home_r, is_explodel, is_exploder,
        output grant_l, grant_r, busy_l, busy_r, kill,
        output score_l, score_r, score_pulse_l, score_pulse_r
    );
endinterface

// File: rtl/catch_arbiter.sv
// Catch arbiter: gives each claw at most one object, never the same object to both,
// holds it through the haul, then credits its value or discards it on dynamite.
// Index 0 of every per-claw array is the left claw, index 1 the right claw.
module catch_arbiter #(
    parameter int unsigned N_OBJ   = 8,
    parameter int unsigned VAL_W   = 8,
    parameter int unsigned SCORE_W = 14
) (
    input  logic           Clk,
    input  logic           reset,
    input  logic           is_new_game_start,
    catch_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    typedef enum logic [1:0] {StIdle, StHaul, StCredit, StBlast} claw_state_e;

    claw_state_e                     state_q [2];
    claw_state_e                     state_d [2];
    logic [1:0][N_OBJ-1:0]           grant_q, grant_d;
    logic [1:0][IDX_W-1:0]           idx_q, idx_d;
    logic [1:0]                      busy_q, busy_d;
    logic [1:0][SCORE_W-1:0]         score_q, score_d;
    logic [1:0]                      pulse_q, pulse_d;
    logic [N_OBJ-1:0]                kill_q, kill_d;
    logic                            tie_q, tie_d;

    logic                            clear;
    logic [1:0][N_OBJ-1:0]           elig;
    logic [1:0]                      pick_vld;
    logic [1:0][IDX_W-1:0]           pick_idx;
    logic                            tie;
    logic [N_OBJ-1:0]                tie_mask;
    logic [1:0][VAL_W-1:0]           val_sel;
    logic [1:0]                      explode;
    logic [1:0]                      home;

    // Lowest set bit of v as {found, index}.
    function automatic logic [IDX_W:0] find_lowest(input logic [N_OBJ-1:0] v);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // Score add that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [VAL_W-1:0]   b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W + 1)'(b);
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    assign clear   = reset | is_new_game_start;
    assign explode = {bus.is_exploder, bus.is_explodel};
    assign home    = {bus.claw_home_r, bus.claw_home_l};

    // Eligibility and object selection, including the alternating tie-break.
    always_comb begin
        tie_mask = '0;
        elig[0]  = bus.hit_l & bus.obj_alive & ~grant_q[1] & ~kill_q;
        elig[1]  = bus.hit_r & bus.obj_alive & ~grant_q[0] & ~kill_q;
        for (int c = 0; c < 2; c++) begin
            {pick_vld[c], pick_idx[c]} = find_lowest(elig[c]);
        end
        tie = (state_q[0] == StIdle) && (state_q[1] == StIdle) &&
              pick_vld[0] && pick_vld[1] && (pick_idx[0] == pick_idx[1]);
        tie_d = tie ? ~tie_q : tie_q;
        if (tie) begin
            tie_mask[pick_idx[0]] = 1'b1;
            // tie_q == 0 lets the left claw keep the contested object
            if (tie_q) begin
                {pick_vld[0], pick_idx[0]} = find_lowest(elig[0] & ~tie_mask);
            end else begin
                {pick_vld[1], pick_idx[1]} = find_lowest(elig[1] & ~tie_mask);
            end
        end
    end

    // Value of the object each claw currently holds.
    always_comb begin
        val_sel = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (idx_q[c] == IDX_W'(i)) begin
                    val_sel[c] = bus.obj_value[i*VAL_W +: VAL_W];
                end
            end
        end
    end

    // Per-claw next state and next registered outputs.
    always_comb begin
        kill_d = '0;
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            grant_d[c] = grant_q[c];
            idx_d[c]   = idx_q[c];
            busy_d[c]  = busy_q[c];
            score_d[c] = score_q[c];
            pulse_d[c] = 1'b0;
            unique case (state_q[c])
                StIdle: begin
                    grant_d[c] = '0;
                    busy_d[c]  = 1'b0;
                    if (pick_vld[c]) begin
                        state_d[c]              = StHaul;
                        idx_d[c]                = pick_idx[c];
                        grant_d[c][pick_idx[c]] = 1'b1;
                        busy_d[c]               = 1'b1;
                    end
                end
                StHaul: begin
                    if (!bus.obj_alive[idx_q[c]]) begin
                        // Object vanished under the claw: drop it silently
                        state_d[c] = StIdle;
                        grant_d[c] = '0;
                        busy_d[c]  = 1'b0;
                    end else if (explode[c]) begin
                        state_d[c] = StBlast;
                        grant_d[c] = '0;
                        busy_d[c]  = 1'b0;
                        kill_d     = kill_d | grant_q[c];
                    end else if (home[c]) begin
                        state_d[c] = StCredit;
                        grant_d[c] = '0;
                        busy_d[c]  = 1'b0;
                        kill_d     = kill_d | grant_q[c];
                        score_d[c] = sat_add(score_q[c], val_sel[c]);
                        pulse_d[c] = 1'b1;
                    end
                end
                StCredit, StBlast: begin
                    state_d[c] = StIdle;
                end
                default: begin
                    state_d[c] = StIdle;
                end
            endcase
        end
    end

    // FSM state and tie-break register.
    always_ff @(posedge Clk) begin
        if (clear) begin
            state_q <= '{StIdle, StIdle};
            idx_q   <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tie_q   <= tie_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk) begin
        if (clear) begin
            grant_q <= '0;
            busy_q  <= '0;
            score_q <= '0;
            pulse_q <= '0;
            kill_q  <= '0;
        end else begin
            grant_q <= grant_d;
            busy_q  <= busy_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            kill_q  <= kill_d;
        end
    end

    assign bus.grant_l       = grant_q[0];
    assign bus.grant_r       = grant_q[1];
    assign bus.busy_l        = busy_q[0];
    assign bus.busy_r        = busy_q[1];
    assign bus.kill          = kill_q;
    assign bus.score_l       = score_q[0];
    assign bus.score_r       = score_q[1];
    assign bus.score_pulse_l = pulse_q[0];
    assign bus.score_pulse_r = pulse_q[1];

endmodule

// File: tb/tb_catch_arbiter.sv
// Bench for catch_arbiter: directed scenarios followed by random play, every cycle
// compared against a behavioural model of which claw holds which object.
module tb_catch_arbiter;
    localparam int SCORE_MAX = 16383;

    logic Clk = 1'b0;
    logic reset;
    logic is_new_game_start;

    int total = 0;
    int bad   = 0;

    catch_arbiter_if #(.N_OBJ(8), .VAL_W(8), .SCORE_W(14)) bus ();

    catch_arbiter #(.N_OBJ(8), .VAL_W(8), .SCORE_W(14)) dut (
        .Clk               (Clk),
        .reset             (reset),
        .is_new_game_start (is_new_game_start),
        .bus               (bus)
    );

    always #5 Clk = ~Clk;

    // Model: which object each claw holds (-1 = none), whether it is finishing a
    // haul this cycle, scores, pulses and the kill vector currently on the outputs.
    int         m_held  [2];
    bit         m_rest  [2];
    int         m_score [2];
    bit         m_pulse [2];
    logic [7:0] m_kill;
    bit         m_tie;

    function automatic int lowest(input logic [7:0] v, input int skip);
        for (int i = 0; i < 8; i++) begin
            if (v[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] vec_of(input int obj);
        logic [7:0] one;
        one = 8'h01;
        return (obj >= 0) ? (one << obj) : 8'h00;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_held[c]  = -1;
            m_rest[c]  = 1'b0;
            m_score[c] = 0;
            m_pulse[c] = 1'b0;
        end
        m_kill = 8'h00;
        m_tie  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs presently driven.
    task automatic model_step();
        logic [7:0] hit [2];
        logic [7:0] elig [2];
        logic [7:0] kill_n;
        bit         home [2];
        bit         expl [2];
        int         pick [2];
        int         w;
        int         h;
        int         v;
        if (reset || is_new_game_start) begin
            model_reset();
            return;
        end
        hit[0]  = bus.hit_l;
        hit[1]  = bus.hit_r;
        home[0] = bus.claw_home_l;
        home[1] = bus.claw_home_r;
        expl[0] = bus.is_explodel;
        expl[1] = bus.is_exploder;
        for (int c = 0; c < 2; c++) begin
            elig[c] = hit[c] & bus.obj_alive & ~vec_of(m_held[1-c]) & ~m_kill;
            pick[c] = (m_held[c] < 0 && !m_rest[c]) ? lowest(elig[c], -1) : -1;
        end
        if (pick[0] >= 0 && pick[0] == pick[1]) begin
            w          = m_tie ? 1 : 0;
            pick[1-w]  = lowest(elig[1-w], pick[w]);
            m_tie      = !m_tie;
        end
        kill_n = 8'h00;
        for (int c = 0; c < 2; c++) begin
            m_pulse[c] = 1'b0;
            if (m_rest[c]) begin
                m_rest[c] = 1'b0;
            end else if (m_held[c] >= 0) begin
                h = m_held[c];
                if (!bus.obj_alive[h]) begin
                    m_held[c] = -1;
                end else if (expl[c]) begin
                    kill_n[h] = 1'b1;
                    m_held[c] = -1;
                    m_rest[c] = 1'b1;
                end else if (home[c]) begin
                    v          = int'(bus.obj_value[h*8 +: 8]);
                    kill_n[h]  = 1'b1;
                    m_score[c] = (m_score[c] + v > SCORE_MAX) ? SCORE_MAX : m_score[c] + v;
                    m_pulse[c] = 1'b1;
                    m_held[c]  = -1;
                    m_rest[c]  = 1'b1;
                end
            end else begin
                m_held[c] = pick[c];
            end
        end
        m_kill = kill_n;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant_l"}, 32'(bus.grant_l), 32'(vec_of(m_held[0])));
        check({tag, ".grant_r"}, 32'(bus.grant_r), 32'(vec_of(m_held[1])));
        check({tag, ".busy_l"}, 32'(bus.busy_l), 32'(m_held[0] >= 0));
        check({tag, ".busy_r"}, 32'(bus.busy_r), 32'(m_held[1] >= 0));
        check({tag, ".kill"}, 32'(bus.kill), 32'(m_kill));
        check({tag, ".score_l"}, 32'(bus.score_l), 32'(m_score[0]));
        check({tag, ".score_r"}, 32'(bus.score_r), 32'(m_score[1]));
        check({tag, ".pulse_l"}, 32'(bus.score_pulse_l), 32'(m_pulse[0]));
        check({tag, ".pulse_r"}, 32'(bus.score_pulse_r), 32'(m_pulse[1]));
        check({tag, ".disjoint"}, 32'(bus.grant_l & bus.grant_r), 32'h0);
        check({tag, ".onehot"}, 32'(($countones(bus.grant_l) <= 1) &&
                                    ($countones(bus.grant_r) <= 1)), 32'h1);
    endtask

    // One clock: predict, let the DUT clock, then compare just after the edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_val(input int obj, input logic [7:0] v);
        bus.obj_value[obj*8 +: 8] = v;
    endtask

    task automatic idle_inputs();
        bus.hit_l       = '0;
        bus.hit_r       = '0;
        bus.claw_home_l = 1'b0;
        bus.claw_home_r = 1'b0;
        bus.is_explodel = 1'b0;
        bus.is_exploder = 1'b0;
    endtask

    // Left claw grabs obj and brings it home, then settles back to idle.
    task automatic haul_l(input int obj, input logic [7:0] v, input string tag);
        set_val(obj, v);
        bus.hit_l = vec_of(obj);
        cycle({tag, ".grab"});
        bus.hit_l       = '0;
        bus.claw_home_l = 1'b1;
        cycle({tag, ".credit"});
        bus.claw_home_l = 1'b0;
        cycle({tag, ".settle"});
    endtask

    initial begin
        reset             = 1'b1;
        is_new_game_start = 1'b0;
        idle_inputs();
        bus.obj_alive = 8'hFF;
        bus.obj_value = '0;
        model_reset();
        cycle("reset");
        check("reset.kill0", 32'(bus.kill), 32'h0);
        reset = 1'b0;
        cycle("idle");

        // Lowest hit object is taken
        bus.hit_l = 8'h0C;
        cycle("t1");
        check("t1.grant_l", 32'(bus.grant_l), 32'h04);
        check("t1.busy_l", 32'(bus.busy_l), 32'h1);
        check("t1.grant_r", 32'(bus.grant_r), 32'h0);

        // Bring obj2 home for 50 points
        bus.hit_l = '0;
        set_val(2, 8'd50);
        bus.claw_home_l = 1'b1;
        cycle("t2");
        check("t2.kill", 32'(bus.kill), 32'h04);
        check("t2.score_l", 32'(bus.score_l), 32'd50);
        check("t2.pulse_l", 32'(bus.score_pulse_l), 32'h1);
        bus.claw_home_l = 1'b0;
        cycle("t2.idle");
        check("t2.kill_off", 32'(bus.kill), 32'h0);

        // Tie on obj0: left first, then right
        bus.hit_l = 8'h03;
        bus.hit_r = 8'h03;
        cycle("t3a");
        check("t3a.grant_l", 32'(bus.grant_l), 32'h01);
        check("t3a.grant_r", 32'(bus.grant_r), 32'h02);
        idle_inputs();
        bus.claw_home_l = 1'b1;
        bus.claw_home_r = 1'b1;
        cycle("t3a.credit");
        check("t3a.kill", 32'(bus.kill), 32'h03);
        idle_inputs();
        cycle("t3a.settle");
        bus.hit_l = 8'h03;
        bus.hit_r = 8'h03;
        cycle("t3b");
        check("t3b.grant_r", 32'(bus.grant_r), 32'h01);
        check("t3b.grant_l", 32'(bus.grant_l), 32'h02);
        idle_inputs();
        bus.claw_home_l = 1'b1;
        bus.claw_home_r = 1'b1;
        cycle("t3b.credit");
        idle_inputs();
        cycle("t3b.settle");

        // Dynamite beats arriving home
        bus.hit_l = 8'h20;
        cycle("t4.grab");
        check("t4.grant_l", 32'(bus.grant_l), 32'h20);
        bus.hit_l       = '0;
        bus.is_explodel = 1'b1;
        bus.claw_home_l = 1'b1;
        cycle("t4.blast");
        check("t4.kill", 32'(bus.kill), 32'h20);
        check("t4.pulse_l", 32'(bus.score_pulse_l), 32'h0);
        idle_inputs();
        cycle("t4.settle");

        // Object destroyed mid-haul
        bus.hit_l = 8'h08;
        cycle("t6.grab");
        bus.hit_l        = '0;
        bus.obj_alive[3] = 1'b0;
        cycle("t6.drop");
        check("t6.grant_l", 32'(bus.grant_l), 32'h0);
        check("t6.busy_l", 32'(bus.busy_l), 32'h0);
        check("t6.kill", 32'(bus.kill), 32'h0);
        bus.obj_alive[3] = 1'b1;
        cycle("t6.idle");

        // Reset while hauling clears everything
        bus.hit_l = 8'h10;
        bus.hit_r = 8'h40;
        cycle("t5r.grab");
        idle_inputs();
        reset = 1'b1;
        cycle("t5r.reset");
        check("t5r.grant_l", 32'(bus.grant_l), 32'h0);
        check("t5r.score_l", 32'(bus.score_l), 32'h0);
        reset = 1'b0;
        cycle("t5r.idle");

        // Climb to 16380, then a 10-point credit saturates
        for (int k = 0; k < 64; k++) haul_l(k % 8, 8'd255, "t5fill");
        haul_l(1, 8'd60, "t5fill");
        check("t5.pre", 32'(bus.score_l), 32'd16380);
        set_val(6, 8'd10);
        bus.hit_l = 8'h40;
        cycle("t5.grab");
        bus.hit_l       = '0;
        bus.claw_home_l = 1'b1;
        cycle("t5.sat");
        check("t5.score_l", 32'(bus.score_l), 32'd16383);
        check("t5.pulse_l", 32'(bus.score_pulse_l), 32'h1);
        bus.claw_home_l = 1'b0;
        cycle("t5.settle");

        // New game clears like reset
        is_new_game_start = 1'b1;
        cycle("ngs");
        check("ngs.score_l", 32'(bus.score_l), 32'h0);
        is_new_game_start = 1'b0;

        // Random play
        for (int n = 0; n < 3000; n++) begin
            bus.hit_l       = 8'($urandom & $urandom);
            bus.hit_r       = 8'($urandom & $urandom);
            bus.claw_home_l = ($urandom_range(0, 3) == 0);
            bus.claw_home_r = ($urandom_range(0, 3) == 0);
            bus.is_explodel = ($urandom_range(0, 9) == 0);
            bus.is_exploder = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.obj_alive[$urandom_range(0, 7)] = ~bus.obj_alive[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 15) == 0) begin
                set_val($urandom_range(0, 7), 8'($urandom));
            end
            is_new_game_start = ($urandom_range(0, 499) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
